rob_core: RTL and testbench
===========================

ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, index width; usable entries 1..2^ROB_WIDTH-1, index 0 = null tag, never allocated.
REQ-002 SHALL have ports clk_in in 1 system clock; rst_in in 1 reset, synchronous, active-low; rdy_in in 1 pause when low.
REQ-003 SHALL have issue_valid in 1 new instruction; issue_type in 2 (0 reg-write, 1 branch, 2 store, 3 other); issue_rd_id in 5 destination register.
REQ-004 SHALL have rob_full out 1 no free entry; issue_rob_idx out ROB_WIDTH index the next issue receives (current tail).
REQ-005 SHALL have cdb_valid in 1; cdb_rob_idx in ROB_WIDTH; cdb_val in 32 result; cdb_mispredict in 1 branch resolved wrong; cdb_redirect_pc in 32 correct target.
REQ-006 SHALL have query1_idx in ROB_WIDTH, query1_ready out 1, query1_val out 32; identical query2_* set.
REQ-007 SHALL have rob_to_rf_ready out 1, rob_to_rf_reg_id out 5, rob_to_rf_reg_val out 32, rob_to_rf_rob_idx out ROB_WIDTH: register commit.
REQ-008 SHALL have rob_to_lsb_commit out 1, rob_to_lsb_rob_idx out ROB_WIDTH: store commit.
REQ-009 SHALL have clr_out out 1 flush pulse; clr_pc_out out 32 refetch PC.

Function
REQ-010 SHALL hold per entry: busy, ready, type, rd_id, val, mispredict, redirect_pc; plus head, tail, count registers.
REQ-011 SHALL use capacity N = 2^ROB_WIDTH-1; head/tail advance max index -> 1, skipping 0.
REQ-012 SHALL drive rob_full = (count == N), combinational.
REQ-013 SHALL allocate on issue_valid && !rob_full && rdy_in: entry[tail] busy=1, ready=0, fields latched, tail advances; issue while full ignored.
REQ-014 SHALL on cdb_valid with busy entry cdb_rob_idx set ready=1, val, mispredict, redirect_pc; CDB to non-busy or index 0 ignored.
REQ-015 SHALL commit at most one entry per cycle: when count>0 and entry[head].ready (registered value), free entry, head advances.
REQ-016 SHALL not commit an entry in the cycle its CDB write arrives; earliest commit is the following cycle.
REQ-017 SHALL register commit outputs: asserted one cycle after the commit edge, single-cycle pulse, low otherwise.
REQ-018 SHALL on commit type 0 pulse rob_to_rf_ready with rd_id, val, head index; rd_id 0 still pulses, downstream discards.
REQ-019 SHALL on commit type 2 pulse rob_to_lsb_commit with head index; types 1, 3 drive no rf/lsb pulse.
REQ-020 SHALL on commit of entry with mispredict=1 pulse clr_out with clr_pc_out=redirect_pc; same edge clear all busy/ready, head=tail=1, count=0; concurrent issue and CDB discarded.
REQ-021 SHALL adjust count: +1 issue only, -1 commit only, unchanged for simultaneous issue and commit (legal when full).
REQ-022 SHALL answer queries combinationally: ready=1, val=cdb_val if cdb_valid and cdb_rob_idx==query idx; else ready/val of stored entry; idx 0 or non-busy -> ready=0, val=0.
REQ-023 SHALL with rdy_in low hold all state, ignore issue and CDB, drive commit/clr pulses low.
REQ-024 SHALL hold clr_pc_out value between pulses; meaningful only while clr_out=1.

Reset
REQ-025 SHALL on rst_in low at clock edge set head=tail=1, count=0, all busy/ready/mispredict 0, all registered outputs 0; issue_rob_idx=1, rob_full=0.
REQ-026 SHALL apply reset mid-operation unconditionally, overriding rdy_in, issue, CDB, commit.

Verification
REQ-027 Reset, issue type0 rd=5 -> idx 1; CDB idx1 val 0xDEAD -> next cycle commit, following cycle rob_to_rf_ready=1, reg_id 5, val 0xDEAD, rob_idx 1.
REQ-028 ROB_WIDTH=4: 15 issues no commit -> rob_full=1 after 15th; 16th ignored; tail wraps to 1 after one commit; index 0 never issued.
REQ-029 Issue idx1, idx2; CDB idx2 first -> no commit; then CDB idx1 -> commits idx1 then idx2 on consecutive cycles, in order.
REQ-030 Branch idx1 CDB mispredict redirect 0x1000, entries idx2-4 busy -> clr_out=1, clr_pc_out=0x1000 one cycle; count 0; next issue gets idx 1.
REQ-031 query1_idx=3 busy not ready, same cycle CDB idx3 val 7 -> query1_ready=1, val 7; query idx 0 -> ready 0.
REQ-032 Full ROB, simultaneous commit and issue -> count stays N, rob_full stays 1; rdy_in low 3 cycles -> no state change, no pulses.

Source files
------------

// File: rtl/rob_core.sv
// rtl/rob_core.sv - reorder buffer with in-order commit, CDB writeback, operand query and mispredict flush
module rob_core #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd_id,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] issue_rob_idx,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob_idx,
    input  logic [31:0]          cdb_val,
    input  logic                 cdb_mispredict,
    input  logic [31:0]          cdb_redirect_pc,
    input  logic [ROB_WIDTH-1:0] query1_idx,
    output logic                 query1_ready,
    output logic [31:0]          query1_val,
    input  logic [ROB_WIDTH-1:0] query2_idx,
    output logic                 query2_ready,
    output logic [31:0]          query2_val,
    output logic                 rob_to_rf_ready,
    output logic [4:0]           rob_to_rf_reg_id,
    output logic [31:0]          rob_to_rf_reg_val,
    output logic [ROB_WIDTH-1:0] rob_to_rf_rob_idx,
    output logic                 rob_to_lsb_commit,
    output logic [ROB_WIDTH-1:0] rob_to_lsb_rob_idx,
    output logic                 clr_out,
    output logic [31:0]          clr_pc_out
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] IDX_MAX   = '1;
    localparam logic [ROB_WIDTH-1:0] IDX_FIRST = ROB_WIDTH'(1);

    logic        busy_q  [DEPTH];
    logic        ready_q [DEPTH];
    logic [1:0]  typ_q   [DEPTH];
    logic [4:0]  rd_q    [DEPTH];
    logic [31:0] val_q   [DEPTH];
    logic        mis_q   [DEPTH];
    logic [31:0] pc_q    [DEPTH];

    logic [ROB_WIDTH-1:0] head_q, tail_q, count_q;
    logic commit_fire, flush, issue_fire, cdb_fire;

    // Index 0 is the null tag, so pointers wrap from the top index straight to 1.
    function automatic logic [ROB_WIDTH-1:0] next_idx(input logic [ROB_WIDTH-1:0] i);
        return (i == IDX_MAX) ? IDX_FIRST : i + 1'b1;
    endfunction

    assign rob_full      = (count_q == IDX_MAX);
    assign issue_rob_idx = tail_q;

    // Commit looks only at the registered ready bit, so a same-cycle CDB write waits a cycle.
    assign commit_fire = rdy_in && (count_q != '0) && ready_q[head_q];
    assign flush       = commit_fire && mis_q[head_q];
    // When full, the committing slot is exactly the tail slot, so a paired issue can reuse it.
    assign issue_fire  = rdy_in && issue_valid && (!rob_full || commit_fire) && !flush;
    assign cdb_fire    = rdy_in && cdb_valid && (cdb_rob_idx != '0) && busy_q[cdb_rob_idx] && !flush;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
                typ_q[i]   <= 2'd0;
                rd_q[i]    <= 5'd0;
                val_q[i]   <= 32'd0;
                mis_q[i]   <= 1'b0;
                pc_q[i]    <= 32'd0;
            end
            head_q             <= IDX_FIRST;
            tail_q             <= IDX_FIRST;
            count_q            <= '0;
            rob_to_rf_ready    <= 1'b0;
            rob_to_rf_reg_id   <= 5'd0;
            rob_to_rf_reg_val  <= 32'd0;
            rob_to_rf_rob_idx  <= '0;
            rob_to_lsb_commit  <= 1'b0;
            rob_to_lsb_rob_idx <= '0;
            clr_out            <= 1'b0;
            clr_pc_out         <= 32'd0;
        end else begin
            rob_to_rf_ready   <= 1'b0;
            rob_to_lsb_commit <= 1'b0;
            clr_out           <= 1'b0;
            if (commit_fire) begin
                rob_to_rf_ready    <= (typ_q[head_q] == 2'd0);
                rob_to_rf_reg_id   <= rd_q[head_q];
                rob_to_rf_reg_val  <= val_q[head_q];
                rob_to_rf_rob_idx  <= head_q;
                rob_to_lsb_commit  <= (typ_q[head_q] == 2'd2);
                rob_to_lsb_rob_idx <= head_q;
                clr_out            <= mis_q[head_q];
                if (mis_q[head_q]) begin
                    clr_pc_out <= pc_q[head_q];
                end
            end

            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
                head_q  <= IDX_FIRST;
                tail_q  <= IDX_FIRST;
                count_q <= '0;
            end else begin
                if (cdb_fire) begin
                    ready_q[cdb_rob_idx] <= 1'b1;
                    val_q[cdb_rob_idx]   <= cdb_val;
                    mis_q[cdb_rob_idx]   <= cdb_mispredict;
                    pc_q[cdb_rob_idx]    <= cdb_redirect_pc;
                end
                if (commit_fire) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= next_idx(head_q);
                end
                if (issue_fire) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    typ_q[tail_q]   <= issue_type;
                    rd_q[tail_q]    <= issue_rd_id;
                    val_q[tail_q]   <= 32'd0;
                    mis_q[tail_q]   <= 1'b0;
                    tail_q          <= next_idx(tail_q);
                end
                case ({issue_fire, commit_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_comb begin
        query1_ready = 1'b0;
        query1_val   = 32'd0;
        if ((query1_idx != '0) && busy_q[query1_idx]) begin
            if (rdy_in && cdb_valid && (cdb_rob_idx == query1_idx)) begin
                query1_ready = 1'b1;
                query1_val   = cdb_val;
            end else begin
                query1_ready = ready_q[query1_idx];
                query1_val   = val_q[query1_idx];
            end
        end
    end

    always_comb begin
        query2_ready = 1'b0;
        query2_val   = 32'd0;
        if ((query2_idx != '0) && busy_q[query2_idx]) begin
            if (rdy_in && cdb_valid && (cdb_rob_idx == query2_idx)) begin
                query2_ready = 1'b1;
                query2_val   = cdb_val;
            end else begin
                query2_ready = ready_q[query2_idx];
                query2_val   = val_q[query2_idx];
            end
        end
    end
endmodule

// File: tb/tb_rob_core.sv
// tb/tb_rob_core.sv - directed and randomized checks of rob_core against an in-order queue model
module tb_rob_core;
    localparam int W = 4;
    localparam int N = (1 << W) - 1;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic         rst_in, rdy_in, issue_valid;
    logic [1:0]   issue_type;
    logic [4:0]   issue_rd_id;
    logic         rob_full;
    logic [W-1:0] issue_rob_idx;
    logic         cdb_valid, cdb_mispredict;
    logic [W-1:0] cdb_rob_idx;
    logic [31:0]  cdb_val, cdb_redirect_pc;
    logic [W-1:0] query1_idx, query2_idx;
    logic         query1_ready, query2_ready;
    logic [31:0]  query1_val, query2_val;
    logic         rob_to_rf_ready, rob_to_lsb_commit, clr_out;
    logic [4:0]   rob_to_rf_reg_id;
    logic [31:0]  rob_to_rf_reg_val, clr_pc_out;
    logic [W-1:0] rob_to_rf_rob_idx, rob_to_lsb_rob_idx;

    rob_core #(.ROB_WIDTH(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd_id(issue_rd_id),
        .rob_full(rob_full), .issue_rob_idx(issue_rob_idx),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_redirect_pc(cdb_redirect_pc),
        .query1_idx(query1_idx), .query1_ready(query1_ready), .query1_val(query1_val),
        .query2_idx(query2_idx), .query2_ready(query2_ready), .query2_val(query2_val),
        .rob_to_rf_ready(rob_to_rf_ready), .rob_to_rf_reg_id(rob_to_rf_reg_id),
        .rob_to_rf_reg_val(rob_to_rf_reg_val), .rob_to_rf_rob_idx(rob_to_rf_rob_idx),
        .rob_to_lsb_commit(rob_to_lsb_commit), .rob_to_lsb_rob_idx(rob_to_lsb_rob_idx),
        .clr_out(clr_out), .clr_pc_out(clr_pc_out)
    );

    typedef struct {
        logic [W-1:0] idx;
        logic [1:0]   typ;
        logic [4:0]   rd;
        logic [31:0]  val;
        bit           rdy;
        bit           mis;
        logic [31:0]  pc;
    } ent_t;

    ent_t        q[$];
    int          m_tail = 1;
    bit          e_rf, e_lsb, e_clr;
    logic [4:0]  e_rf_id;
    logic [31:0] e_rf_val, e_clr_pc;
    logic [W-1:0] e_rf_idx, e_lsb_idx;
    int          n_checks = 0, n_fail = 0;

    // Program-order model: the oldest instruction is q[0]; commit and flush follow the rules directly.
    task automatic model_edge();
        ent_t h, e;
        bit commit, full;
        e_rf = 0; e_lsb = 0; e_clr = 0;
        if (!rst_in) begin
            q.delete(); m_tail = 1; e_clr_pc = '0;
            return;
        end
        if (!rdy_in) return;
        full   = (q.size() == N);
        commit = (q.size() > 0) && q[0].rdy;
        if (commit) begin
            h = q[0];
            e_rf = (h.typ == 2'd0); e_rf_id = h.rd; e_rf_val = h.val; e_rf_idx = h.idx;
            e_lsb = (h.typ == 2'd2); e_lsb_idx = h.idx;
            e_clr = h.mis;
            if (h.mis) begin
                e_clr_pc = h.pc; q.delete(); m_tail = 1;
                return;
            end
        end
        if (cdb_valid)
            foreach (q[i])
                if (q[i].idx == cdb_rob_idx) begin
                    q[i].rdy = 1; q[i].val = cdb_val; q[i].mis = cdb_mispredict; q[i].pc = cdb_redirect_pc;
                end
        if (commit) void'(q.pop_front());
        if (issue_valid && (!full || commit)) begin
            e.idx = W'(m_tail); e.typ = issue_type; e.rd = issue_rd_id;
            e.val = '0; e.rdy = 0; e.mis = 0; e.pc = '0;
            q.push_back(e);
            m_tail = m_tail % N + 1;
        end
    endtask

    function automatic logic [32:0] m_query(input logic [W-1:0] idx);
        m_query = '0;
        foreach (q[i])
            if (q[i].idx == idx) begin
                if (rdy_in && cdb_valid && cdb_rob_idx == idx) m_query = {1'b1, cdb_val};
                else if (q[i].rdy) m_query = {1'b1, q[i].val};
            end
    endfunction

    function automatic logic [41:0] got_rf();
        return {rob_to_rf_ready, rob_to_rf_ready ? {rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx} : 41'd0};
    endfunction
    function automatic logic [41:0] exp_rf();
        return {e_rf, e_rf ? {e_rf_id, e_rf_val, e_rf_idx} : 41'd0};
    endfunction
    function automatic logic [37:0] got_misc();
        return {rob_to_lsb_commit, rob_to_lsb_commit ? rob_to_lsb_rob_idx : 4'd0, clr_out, clr_out ? clr_pc_out : 32'd0};
    endfunction
    function automatic logic [37:0] exp_misc();
        return {e_lsb, e_lsb ? e_lsb_idx : 4'd0, e_clr, e_clr ? e_clr_pc : 32'd0};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_type = 0; issue_rd_id = 0;
        cdb_valid = 0; cdb_rob_idx = 0; cdb_val = 0; cdb_mispredict = 0; cdb_redirect_pc = 0;
        query1_idx = 0; query2_idx = 0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd);
        issue_valid = 1; issue_type = t; issue_rd_id = rd;
    endtask

    task automatic set_cdb(input logic [W-1:0] idx, input logic [31:0] v, input logic mis, input logic [31:0] pc);
        cdb_valid = 1; cdb_rob_idx = idx; cdb_val = v; cdb_mispredict = mis; cdb_redirect_pc = pc;
    endtask

    task automatic do_reset();
        rst_in = 0; rdy_in = 1; idle();
        tick(); tick();
        rst_in = 1;
    endtask

    task automatic fill_rob();
        for (int i = 1; i <= N; i++) begin
            idle(); set_issue(2'd0, 5'(i)); tick();
        end
        idle();
    endtask

    task automatic test_reset();
        rst_in = 0; rdy_in = 0;
        set_issue(2'd2, 5'd3); set_cdb(4'd1, 32'h55, 1'b1, 32'h99);
        tick(); rdy_in = 1; tick();
        rst_in = 1; idle(); #1;
        n_checks++;
        if ({rob_full, issue_rob_idx} !== {1'b0, 4'd1}) begin
            n_fail++; $display("FAIL reset_ptrs got full=%b idx=%0d want full=0 idx=1", rob_full, issue_rob_idx);
        end
        n_checks++;
        if ({rob_to_rf_ready, rob_to_lsb_commit, clr_out, clr_pc_out} !== 35'd0) begin
            n_fail++; $display("FAIL reset_outs got rf=%b lsb=%b clr=%b pc=%h want all 0", rob_to_rf_ready, rob_to_lsb_commit, clr_out, clr_pc_out);
        end
    endtask

    task automatic test_basic_commit();
        do_reset();
        set_issue(2'd0, 5'd5); #1;
        n_checks++;
        if (issue_rob_idx !== 4'd1) begin
            n_fail++; $display("FAIL basic_issue_idx got %0d want 1", issue_rob_idx);
        end
        tick();
        idle(); set_cdb(4'd1, 32'hDEAD, 1'b0, 32'h0); tick();
        n_checks++;
        if (rob_to_rf_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_no_early_commit got rf_ready=%b want 0", rob_to_rf_ready);
        end
        idle(); tick();
        n_checks++;
        if ({rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx} !== {1'b1, 5'd5, 32'hDEAD, 4'd1}) begin
            n_fail++; $display("FAIL basic_rf_commit got %b/%0d/%h/%0d want 1/5/dead/1", rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx);
        end
        tick();
        n_checks++;
        if (rob_to_rf_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_single_pulse got rf_ready=%b want 0", rob_to_rf_ready);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 1; i <= N; i++) begin
            idle(); set_issue(2'd0, 5'(i)); #1;
            n_checks++;
            if (issue_rob_idx !== W'(i) || rob_full !== 1'b0) begin
                n_fail++; $display("FAIL full_issue_idx got idx=%0d full=%b want idx=%0d full=0", issue_rob_idx, rob_full, i);
            end
            tick();
        end
        idle(); #1;
        n_checks++;
        if ({rob_full, issue_rob_idx} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL full_flag got full=%b idx=%0d want full=1 idx=1", rob_full, issue_rob_idx);
        end
        set_issue(2'd0, 5'd31); tick();
        idle(); set_cdb(4'd1, 32'h1234, 1'b0, 32'h0); tick();
        idle(); tick();
        n_checks++;
        if ({rob_full, issue_rob_idx, rob_to_rf_ready, rob_to_rf_reg_id} !== {1'b0, 4'd1, 1'b1, 5'd1}) begin
            n_fail++; $display("FAIL full_after_commit got full=%b idx=%0d rf=%b rd=%0d want 0/1/1/1", rob_full, issue_rob_idx, rob_to_rf_ready, rob_to_rf_reg_id);
        end
        set_issue(2'd3, 5'd0); tick(); idle(); #1;
        n_checks++;
        if ({rob_full, issue_rob_idx} !== {1'b1, 4'd2}) begin
            n_fail++; $display("FAIL full_refill got full=%b idx=%0d want full=1 idx=2", rob_full, issue_rob_idx);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        set_issue(2'd0, 5'd7); tick();
        set_issue(2'd0, 5'd9); tick();
        idle(); set_cdb(4'd2, 32'h22, 1'b0, 32'h0); tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (rob_to_rf_ready !== 1'b0) begin
                n_fail++; $display("FAIL order_hold got rf_ready=%b idx=%0d want 0", rob_to_rf_ready, rob_to_rf_rob_idx);
            end
        end
        set_cdb(4'd1, 32'h11, 1'b0, 32'h0); tick();
        idle(); tick();
        n_checks++;
        if ({rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx} !== {1'b1, 5'd7, 32'h11, 4'd1}) begin
            n_fail++; $display("FAIL order_first got %b/%0d/%h/%0d want 1/7/11/1", rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx);
        end
        tick();
        n_checks++;
        if ({rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx} !== {1'b1, 5'd9, 32'h22, 4'd2}) begin
            n_fail++; $display("FAIL order_second got %b/%0d/%h/%0d want 1/9/22/2", rob_to_rf_ready, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        set_issue(2'd1, 5'd0); tick();
        for (int i = 2; i <= 4; i++) begin
            set_issue(2'd0, 5'(i)); tick();
        end
        idle(); set_cdb(4'd1, 32'h0, 1'b1, 32'h1000); tick();
        idle(); set_issue(2'd0, 5'd6); set_cdb(4'd2, 32'h77, 1'b0, 32'h0); tick();
        n_checks++;
        if ({clr_out, clr_pc_out, rob_to_rf_ready, rob_to_lsb_commit} !== {1'b1, 32'h1000, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL flush_pulse got clr=%b pc=%h rf=%b lsb=%b want 1/1000/0/0", clr_out, clr_pc_out, rob_to_rf_ready, rob_to_lsb_commit);
        end
        idle(); query1_idx = 4'd2; #1;
        n_checks++;
        if ({rob_full, issue_rob_idx, query1_ready} !== {1'b0, 4'd1, 1'b0}) begin
            n_fail++; $display("FAIL flush_state got full=%b idx=%0d q2rdy=%b want 0/1/0", rob_full, issue_rob_idx, query1_ready);
        end
        tick();
        n_checks++;
        if ({clr_out, clr_pc_out} !== {1'b0, 32'h1000}) begin
            n_fail++; $display("FAIL flush_hold got clr=%b pc=%h want 0/1000", clr_out, clr_pc_out);
        end
    endtask

    task automatic test_query_bypass();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_issue(2'd0, 5'(i)); tick();
        end
        idle(); query1_idx = 4'd3; query2_idx = 4'd0; set_cdb(4'd3, 32'd7, 1'b0, 32'h0); #1;
        n_checks++;
        if ({query1_ready, query1_val, query2_ready} !== {1'b1, 32'd7, 1'b0}) begin
            n_fail++; $display("FAIL query_bypass got q1=%b/%0d q2rdy=%b want 1/7/0", query1_ready, query1_val, query2_ready);
        end
        query2_idx = 4'd2; #1;
        n_checks++;
        if (query2_ready !== 1'b0) begin
            n_fail++; $display("FAIL query_not_ready got q2rdy=%b want 0", query2_ready);
        end
        tick(); cdb_valid = 0; #1;
        n_checks++;
        if ({query1_ready, query1_val} !== {1'b1, 32'd7}) begin
            n_fail++; $display("FAIL query_stored got %b/%0d want 1/7", query1_ready, query1_val);
        end
    endtask

    task automatic test_full_swap_and_pause();
        do_reset();
        fill_rob();
        set_cdb(4'd1, 32'hAB, 1'b0, 32'h0); tick();
        idle(); set_issue(2'd2, 5'd0); #1;
        n_checks++;
        if (rob_full !== 1'b1) begin
            n_fail++; $display("FAIL swap_pre_full got %b want 1", rob_full);
        end
        tick();
        n_checks++;
        if ({rob_full, issue_rob_idx, rob_to_rf_ready, rob_to_rf_reg_val, rob_to_rf_rob_idx} !== {1'b1, 4'd2, 1'b1, 32'hAB, 4'd1}) begin
            n_fail++; $display("FAIL swap_post got full=%b idx=%0d rf=%b val=%h ridx=%0d want 1/2/1/ab/1", rob_full, issue_rob_idx, rob_to_rf_ready, rob_to_rf_reg_val, rob_to_rf_rob_idx);
        end
        rdy_in = 0; set_issue(2'd0, 5'd4); set_cdb(4'd2, 32'h33, 1'b1, 32'h44);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({rob_to_rf_ready, rob_to_lsb_commit, clr_out, rob_full, issue_rob_idx} !== {3'b000, 1'b1, 4'd2}) begin
                n_fail++; $display("FAIL pause_hold got rf=%b lsb=%b clr=%b full=%b idx=%0d want 0/0/0/1/2", rob_to_rf_ready, rob_to_lsb_commit, clr_out, rob_full, issue_rob_idx);
            end
        end
        rdy_in = 1; idle(); query1_idx = 4'd2; #1;
        n_checks++;
        if (query1_ready !== 1'b0) begin
            n_fail++; $display("FAIL pause_cdb_ignored got q1rdy=%b want 0", query1_ready);
        end
    endtask

    task automatic test_random();
        logic [32:0] mq1, mq2;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            idle();
            rst_in = ($urandom_range(0, 99) != 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            issue_valid = $urandom_range(0, 1);
            issue_type  = 2'($urandom_range(0, 3));
            issue_rd_id = 5'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                cdb_valid = 1;
                cdb_val = $urandom; cdb_redirect_pc = $urandom;
                cdb_mispredict = ($urandom_range(0, 15) == 0);
                if (q.size() > 0 && $urandom_range(0, 3) != 0) cdb_rob_idx = q[$urandom_range(0, q.size() - 1)].idx;
                else cdb_rob_idx = W'($urandom_range(0, N));
            end
            query1_idx = (cdb_valid && $urandom_range(0, 1)) ? cdb_rob_idx : W'($urandom_range(0, N));
            query2_idx = W'($urandom_range(0, N));
            #1;
            if (rst_in) begin
                mq1 = m_query(query1_idx); mq2 = m_query(query2_idx);
                n_checks++;
                if ({rob_full, issue_rob_idx} !== {(q.size() == N), W'(m_tail)}) begin
                    n_fail++; $display("FAIL rand_alloc c=%0d got full=%b idx=%0d want full=%b idx=%0d", c, rob_full, issue_rob_idx, q.size() == N, m_tail);
                end
                n_checks++;
                if ({query1_ready, query1_ready ? query1_val : 32'd0, query2_ready, query2_ready ? query2_val : 32'd0} !== {mq1, mq2}) begin
                    n_fail++; $display("FAIL rand_query c=%0d got %b/%h %b/%h want %h %h", c, query1_ready, query1_val, query2_ready, query2_val, mq1, mq2);
                end
            end
            tick();
            n_checks++;
            if (got_rf() !== exp_rf()) begin
                n_fail++; $display("FAIL rand_rf_commit c=%0d got %h want %h", c, got_rf(), exp_rf());
            end
            n_checks++;
            if (got_misc() !== exp_misc()) begin
                n_fail++; $display("FAIL rand_lsb_clr c=%0d got %h want %h", c, got_misc(), exp_misc());
            end
        end
        rst_in = 1; rdy_in = 1; idle();
    endtask

    initial begin
        rst_in = 0; rdy_in = 1; idle();
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_in_order();
        test_mispredict();
        test_query_bypass();
        test_full_swap_and_pause();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
